// File: rtl/ex_div_seq_pkg.sv
// Shared operation/state encodings and op-decode helpers for the EX-stage divider.
package ex_div_seq_pkg;

  typedef enum logic [1:0] {
    DIV_OP_DIV_W  = 2'b00,
    DIV_OP_MOD_W  = 2'b01,
    DIV_OP_DIV_WU = 2'b10,
    DIV_OP_MOD_WU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    DIV_ST_IDLE = 2'b00,
    DIV_ST_RUN  = 2'b01,
    DIV_ST_DONE = 2'b10
  } div_st_e;

  function automatic logic op_is_signed(input div_op_e op);
    return (op == DIV_OP_DIV_W) || (op == DIV_OP_MOD_W);
  endfunction

  function automatic logic op_is_mod(input div_op_e op);
    return (op == DIV_OP_MOD_W) || (op == DIV_OP_MOD_WU);
  endfunction

endpackage

// File: rtl/ex_div_seq_if.sv
// EX-stage <-> divider handshake: request/operands in, stall and result out.
interface ex_div_seq_if #(
  parameter int DATA_W = 32
);
  logic              ex_div_req;
  logic [1:0]        ex_div_op;
  logic [DATA_W-1:0] ex_src_j;
  logic [DATA_W-1:0] ex_src_k;
  logic              ex_advance;
  logic              ex_cancel;
  logic              ex_exe_out_valid;
  logic [DATA_W-1:0] div_result;
  logic              div_busy;

  modport master (
    output ex_div_req, ex_div_op, ex_src_j, ex_src_k, ex_advance, ex_cancel,
    input  ex_exe_out_valid, div_result, div_busy
  );

  modport slave (
    input  ex_div_req, ex_div_op, ex_src_j, ex_src_k, ex_advance, ex_cancel,
    output ex_exe_out_valid, div_result, div_busy
  );
endinterface

// File: rtl/ex_div_seq_iter_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// subtract the divisor when it fits, and shift the resulting quotient bit in.
module ex_div_seq_iter_step #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rem_i,
  input  logic [DATA_W-1:0] quo_i,
  input  logic [DATA_W-1:0] dvs_i,
  output logic [DATA_W-1:0] rem_o,
  output logic [DATA_W-1:0] quo_o
);

  logic [DATA_W:0]   shifted;
  logic [DATA_W-1:0] diff;
  logic              ge;

  // The true difference fits in DATA_W bits whenever ge holds, so modulo arithmetic suffices.
  always_comb begin
    shifted = {rem_i, quo_i[DATA_W-1]};
    ge      = (shifted >= {1'b0, dvs_i});
    diff    = shifted[DATA_W-1:0] - dvs_i;
    if (ge) begin
      rem_o = diff;
    end else begin
      rem_o = shifted[DATA_W-1:0];
    end
    quo_o = {quo_i[DATA_W-2:0], ge};
  end

endmodule

// File: rtl/ex_div_seq.sv
// Sequencer for div.w/mod.w/div.wu/mod.wu in EX: stalls the pipe until the result is ready.
// Optional build macro DIV_FAST_PATH_EN: trivial divisions (k==0 or |j|<|k|) finish without RUN.
module ex_div_seq
  import ex_div_seq_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int STEPS_PC = 1
) (
  input  logic         clk,
  input  logic         resetn,
  ex_div_seq_if.slave  bus
);

  localparam int RUN_CYC = DATA_W / STEPS_PC;
  localparam int CNT_W   = (RUN_CYC > 1) ? $clog2(RUN_CYC) : 1;

  function automatic logic [DATA_W-1:0] twos_neg(input logic [DATA_W-1:0] v);
    return (~v) + {{(DATA_W-1){1'b0}}, 1'b1};
  endfunction

  div_st_e           state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] rem_q;
  logic [DATA_W-1:0] quo_q;
  logic [DATA_W-1:0] dvs_q;
  div_op_e           op_q;
  logic              sj_q;
  logic              sk_q;
  logic [DATA_W-1:0] res_q;
  logic              busy_q;

  div_op_e           op_s;
  logic              sgn_s;
  logic              j_neg_s;
  logic              k_neg_s;
  logic [DATA_W-1:0] abs_j_s;
  logic [DATA_W-1:0] abs_k_s;
  logic [DATA_W-1:0] fast_res_s;
  logic              fast_s;

  // Operand decode at request time: absolute values and the trivial-case result.
  always_comb begin
    op_s    = div_op_e'(bus.ex_div_op);
    sgn_s   = op_is_signed(op_s);
    j_neg_s = sgn_s & bus.ex_src_j[DATA_W-1];
    k_neg_s = sgn_s & bus.ex_src_k[DATA_W-1];
    if (j_neg_s) begin
      abs_j_s = twos_neg(bus.ex_src_j);
    end else begin
      abs_j_s = bus.ex_src_j;
    end
    if (k_neg_s) begin
      abs_k_s = twos_neg(bus.ex_src_k);
    end else begin
      abs_k_s = bus.ex_src_k;
    end
    if (op_is_mod(op_s)) begin
      fast_res_s = bus.ex_src_j;
    end else if (abs_k_s == {DATA_W{1'b0}}) begin
      fast_res_s = {DATA_W{1'b1}};
    end else begin
      fast_res_s = {DATA_W{1'b0}};
    end
  end

`ifdef DIV_FAST_PATH_EN
  assign fast_s = (abs_k_s == {DATA_W{1'b0}}) || (abs_j_s < abs_k_s);
`else
  assign fast_s = 1'b0;
`endif

  logic [DATA_W-1:0] rem_a_s;
  logic [DATA_W-1:0] quo_a_s;
  logic [DATA_W-1:0] rem_n_s;
  logic [DATA_W-1:0] quo_n_s;

  ex_div_seq_iter_step #(.DATA_W(DATA_W)) u_step0 (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvs_i (dvs_q),
    .rem_o (rem_a_s),
    .quo_o (quo_a_s)
  );

  if (STEPS_PC == 2) begin : g_step2
    logic [DATA_W-1:0] rem_b_s;
    logic [DATA_W-1:0] quo_b_s;

    ex_div_seq_iter_step #(.DATA_W(DATA_W)) u_step1 (
      .rem_i (rem_a_s),
      .quo_i (quo_a_s),
      .dvs_i (dvs_q),
      .rem_o (rem_b_s),
      .quo_o (quo_b_s)
    );

    assign rem_n_s = rem_b_s;
    assign quo_n_s = quo_b_s;
  end else begin : g_step1
    assign rem_n_s = rem_a_s;
    assign quo_n_s = quo_a_s;
  end

  logic [DATA_W-1:0] q_fix_s;
  logic [DATA_W-1:0] r_fix_s;
  logic [DATA_W-1:0] res_fix_s;

  // Sign fix-up of the final step: a zero divisor keeps the raw all-ones quotient.
  always_comb begin
    if (op_is_signed(op_q) && (sj_q ^ sk_q) && (dvs_q != {DATA_W{1'b0}})) begin
      q_fix_s = twos_neg(quo_n_s);
    end else begin
      q_fix_s = quo_n_s;
    end
    if (op_is_signed(op_q) && sj_q) begin
      r_fix_s = twos_neg(rem_n_s);
    end else begin
      r_fix_s = rem_n_s;
    end
    if (op_is_mod(op_q)) begin
      res_fix_s = r_fix_s;
    end else begin
      res_fix_s = q_fix_s;
    end
  end

  // Control FSM with iteration registers and the registered result/busy outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= DIV_ST_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      rem_q   <= {DATA_W{1'b0}};
      quo_q   <= {DATA_W{1'b0}};
      dvs_q   <= {DATA_W{1'b0}};
      op_q    <= DIV_OP_DIV_W;
      sj_q    <= 1'b0;
      sk_q    <= 1'b0;
      res_q   <= {DATA_W{1'b0}};
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        DIV_ST_IDLE: begin
          if (!bus.ex_cancel && bus.ex_div_req) begin
            rem_q  <= {DATA_W{1'b0}};
            quo_q  <= abs_j_s;
            dvs_q  <= abs_k_s;
            op_q   <= op_s;
            sj_q   <= j_neg_s;
            sk_q   <= k_neg_s;
            busy_q <= 1'b1;
            if (fast_s) begin
              res_q   <= fast_res_s;
              state_q <= DIV_ST_DONE;
            end else begin
              cnt_q   <= CNT_W'(RUN_CYC - 1);
              state_q <= DIV_ST_RUN;
            end
          end
        end
        DIV_ST_RUN: begin
          if (bus.ex_cancel) begin
            state_q <= DIV_ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            rem_q <= rem_n_s;
            quo_q <= quo_n_s;
            if (cnt_q == {CNT_W{1'b0}}) begin
              res_q   <= res_fix_s;
              state_q <= DIV_ST_DONE;
            end else begin
              cnt_q <= cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
            end
          end
        end
        DIV_ST_DONE: begin
          if (bus.ex_cancel || bus.ex_advance) begin
            state_q <= DIV_ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= DIV_ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // The stall output must react to the request in the same cycle, so it stays combinational.
  assign bus.ex_exe_out_valid = ((state_q == DIV_ST_IDLE) && !bus.ex_div_req)
                              || (state_q == DIV_ST_DONE)
                              || bus.ex_cancel;
  assign bus.div_result       = res_q;
  assign bus.div_busy         = busy_q;

endmodule

// File: tb/tb_ex_div_seq.sv
// Self-checking bench for ex_div_seq: arithmetic reference model plus directed literal cases.
module tb_ex_div_seq;

  logic clk    = 1'b0;
  logic resetn = 1'b0;

  always #5 clk = ~clk;

  ex_div_seq_if #(.DATA_W(32)) bus ();

  ex_div_seq #(.DATA_W(32), .STEPS_PC(1)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference arithmetic: signed truncating division, remainder follows dividend.
  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] j,
                                          input logic [31:0] k);
    logic [31:0] q;
    logic [31:0] r;
    if (k == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = j;
    end else if (!op[1]) begin
      if (j == 32'h8000_0000 && k == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000;
        r = 32'd0;
      end else begin
        q = $signed(j) / $signed(k);
        r = $signed(j) % $signed(k);
      end
    end else begin
      q = j / k;
      r = j % k;
    end
    return op[0] ? r : q;
  endfunction

  function automatic bit fast_pred(input logic [1:0] op, input logic [31:0] j,
                                   input logic [31:0] k);
`ifdef DIV_FAST_PATH_EN
    logic [31:0] aj;
    logic [31:0] ak;
    aj = (!op[1] && j[31]) ? (32'd0 - j) : j;
    ak = (!op[1] && k[31]) ? (32'd0 - k) : k;
    return (k == 32'd0) || (aj < ak);
`else
    return (op == 2'b00) && (j != j) && (k != k);
`endif
  endfunction

  // Behavioural model: 0 idle, 1 computing (latency countdown), 2 result held.
  int          m_phase = 0;
  int          m_left  = 0;
  logic [31:0] m_res   = 32'd0;
  logic [31:0] m_pend  = 32'd0;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_phase <= 0;
      m_left  <= 0;
      m_res   <= 32'd0;
    end else if (bus.ex_cancel) begin
      m_phase <= 0;
    end else begin
      case (m_phase)
        0: if (bus.ex_div_req) begin
          if (fast_pred(bus.ex_div_op, bus.ex_src_j, bus.ex_src_k)) begin
            m_res   <= ref_div(bus.ex_div_op, bus.ex_src_j, bus.ex_src_k);
            m_phase <= 2;
          end else begin
            m_pend  <= ref_div(bus.ex_div_op, bus.ex_src_j, bus.ex_src_k);
            m_left  <= 32;
            m_phase <= 1;
          end
        end
        1: begin
          m_left <= m_left - 1;
          if (m_left == 1) begin
            m_res   <= m_pend;
            m_phase <= 2;
          end
        end
        2: if (bus.ex_advance) m_phase <= 0;
        default: m_phase <= 0;
      endcase
    end
  end

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_out_valid", {31'd0, bus.ex_exe_out_valid},
          {31'd0, ((m_phase == 0) && !bus.ex_div_req) || (m_phase == 2) || bus.ex_cancel});
      chk("cyc_busy", {31'd0, bus.div_busy}, {31'd0, (m_phase != 0)});
      chk("cyc_result", bus.div_result, m_res);
    end
  end

  task automatic run_case(input string nm, input logic [1:0] op, input logic [31:0] j,
                          input logic [31:0] k, input logic [31:0] exp, input int hold);
    int lat;
    int exp_lat;
    chk({nm, "_model"}, ref_div(op, j, k), exp);
    exp_lat = fast_pred(op, j, k) ? 1 : 33;
    bus.ex_div_op  = op;
    bus.ex_src_j   = j;
    bus.ex_src_k   = k;
    bus.ex_div_req = 1'b1;
    #1;
    chk({nm, "_stall"}, {31'd0, bus.ex_exe_out_valid}, 32'd0);
    lat = 0;
    while (bus.ex_exe_out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk);
      #1;
      lat = lat + 1;
      if (lat == 3) begin
        bus.ex_src_j  = ~j;
        bus.ex_src_k  = 32'd3;
        bus.ex_div_op = op ^ 2'b01;
      end
    end
    chk({nm, "_latency"}, lat, exp_lat);
    chk({nm, "_result"}, bus.div_result, exp);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      chk({nm, "_hold_valid"}, {31'd0, bus.ex_exe_out_valid}, 32'd1);
      chk({nm, "_hold_busy"}, {31'd0, bus.div_busy}, 32'd1);
      chk({nm, "_hold_result"}, bus.div_result, exp);
    end
    bus.ex_advance = 1'b1;
    @(posedge clk);
    #1;
    bus.ex_advance = 1'b0;
    bus.ex_div_req = 1'b0;
    #1;
    chk({nm, "_idle_busy"}, {31'd0, bus.div_busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  logic [31:0] last_res;

  initial begin
    bus.ex_div_req = 1'b0;
    bus.ex_div_op  = 2'b00;
    bus.ex_src_j   = 32'd0;
    bus.ex_src_k   = 32'd0;
    bus.ex_advance = 1'b0;
    bus.ex_cancel  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    chk("reset_result", bus.div_result, 32'd0);
    chk("reset_busy", {31'd0, bus.div_busy}, 32'd0);
    chk("reset_valid", {31'd0, bus.ex_exe_out_valid}, 32'd1);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    run_case("divw_100_7", 2'b00, 32'd100, 32'd7, 32'd14, 3);
    run_case("modw_100_7", 2'b01, 32'd100, 32'd7, 32'd2, 0);
    run_case("divw_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0);
    run_case("modw_m7_2", 2'b01, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0);
    run_case("divwu_big_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 0);
    run_case("divw_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
    run_case("modw_ovf", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0);
    run_case("divwu_5_0", 2'b10, 32'd5, 32'd0, 32'hFFFF_FFFF, 0);
    run_case("modwu_5_0", 2'b11, 32'd5, 32'd0, 32'd5, 0);
    run_case("modw_m100_7", 2'b01, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 0);
    run_case("divw_max_m2", 2'b00, 32'h7FFF_FFFF, 32'hFFFF_FFFE, 32'hC000_0001, 0);
    run_case("divw_m7_0", 2'b00, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 0);
    run_case("modw_m7_0", 2'b01, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 0);
    last_res = 32'hFFFF_FFF9;

    // Cancel wins over a request in IDLE.
    bus.ex_div_op  = 2'b00;
    bus.ex_src_j   = 32'd50;
    bus.ex_src_k   = 32'd5;
    bus.ex_div_req = 1'b1;
    bus.ex_cancel  = 1'b1;
    #1;
    chk("idle_cancel_valid", {31'd0, bus.ex_exe_out_valid}, 32'd1);
    @(posedge clk);
    #1;
    bus.ex_cancel  = 1'b0;
    bus.ex_div_req = 1'b0;
    #1;
    chk("idle_cancel_busy", {31'd0, bus.div_busy}, 32'd0);
    chk("idle_cancel_result", bus.div_result, last_res);

    // Cancel in the tenth RUN cycle.
    bus.ex_src_j   = 32'd1000;
    bus.ex_src_k   = 32'd3;
    bus.ex_div_req = 1'b1;
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    chk("run_busy", {31'd0, bus.div_busy}, 32'd1);
    chk("run_stall", {31'd0, bus.ex_exe_out_valid}, 32'd0);
    bus.ex_cancel = 1'b1;
    #1;
    chk("run_cancel_valid", {31'd0, bus.ex_exe_out_valid}, 32'd1);
    @(posedge clk);
    #1;
    bus.ex_cancel  = 1'b0;
    bus.ex_div_req = 1'b0;
    #1;
    chk("run_cancel_busy", {31'd0, bus.div_busy}, 32'd0);
    chk("run_cancel_result", bus.div_result, last_res);
    run_case("divwu_9_3", 2'b10, 32'd9, 32'd3, 32'd3, 0);

    // Reset pulse in the middle of RUN.
    bus.ex_div_op  = 2'b00;
    bus.ex_src_j   = 32'd100;
    bus.ex_src_k   = 32'd7;
    bus.ex_div_req = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    #2;
    resetn         = 1'b0;
    bus.ex_div_req = 1'b0;
    #1;
    chk("rst_busy", {31'd0, bus.div_busy}, 32'd0);
    chk("rst_result", bus.div_result, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    run_case("divw_3_7", 2'b00, 32'd3, 32'd7, 32'd0, 0);
    run_case("modw_3_7", 2'b01, 32'd3, 32'd7, 32'd3, 1);

    @(posedge clk);
    #1;
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
